fdtd_tile_sched: RTL

//  Tile-level sequencer for the fdtd-2d accelerator. Splits one job into num_tiles tiles.

---
 rtl/fdtd_sched_pkg.sv | 21 ++
 rtl/fdtd_sched_wdog.sv | 28 ++
 rtl/fdtd_tile_sched.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fdtd_sched_pkg.sv
// Shared types and constants for the fdtd-2d tile scheduler.
package fdtd_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KSTART,
    S_KRUN,
    S_STORE,
    S_NEXT,
    S_FINISH
  } state_t;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_CFG = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;
  localparam logic [1:0] ERR_ABT = 2'd3;

  localparam int TILE_W_DEF = 16;

endpackage

// File: rtl/fdtd_sched_wdog.sv
// Per-phase cycle counter; expire is high on the CYCLES-th enabled cycle since the last clear.
module fdtd_sched_wdog #(
  parameter int unsigned CYCLES = 32'd1 << 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(CYCLES) + 1;

  logic [W-1:0] count_reg;

  assign expire = enable && (count_reg == W'(CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expire) begin
      count_reg <= count_reg + W'(1);
    end
  end

endmodule

// File: rtl/fdtd_tile_sched.sv
// Tile sequencer: load -> kernel (ap_ctrl_hs) -> store per tile, with address generation.
// Define FDTD_TILE_SCHED_WDOG_EN to build in the per-phase watchdog (timeout reported as err=2).
module fdtd_tile_sched
  import fdtd_sched_pkg::*;
#(
  parameter int          ADDR_WID    = 14,
  parameter int          TILE_W      = TILE_W_DEF,
  parameter int unsigned WDOG_CYCLES = 32'd1 << 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [TILE_W-1:0]   num_tiles,
  input  logic [ADDR_WID:0]   tile_words,
  input  logic [63:0]         read_base,
  input  logic [63:0]         write_base,
  input  logic [63:0]         tile_stride,
  output logic                ld_req,
  output logic [63:0]         ld_addr,
  output logic [ADDR_WID:0]   ld_len,
  input  logic                ld_done,
  output logic                ap_start,
  input  logic                ap_ready,
  input  logic                ap_done,
  output logic                st_req,
  output logic [63:0]         st_addr,
  output logic [ADDR_WID:0]   st_len,
  input  logic                st_done,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err,
  output logic [TILE_W-1:0]   tile_idx
);

  localparam logic [ADDR_WID:0] MAX_WORDS = {1'b1, {ADDR_WID{1'b0}}};

  state_t              state_reg, state_next;
  logic [1:0]          err_reg, err_next;
  logic [TILE_W-1:0]   tile_reg, tile_next;
  logic [TILE_W-1:0]   ntiles_reg, ntiles_next;
  logic [ADDR_WID:0]   len_reg, len_next;
  logic [63:0]         rd_addr_reg, rd_addr_next;
  logic [63:0]         wr_addr_reg, wr_addr_next;
  logic [63:0]         stride_reg, stride_next;

  logic                cfg_bad;
  logic                stop;
  logic                wdog_expire;
  logic [TILE_W-1:0]   tile_inc;

  assign cfg_bad  = (tile_words == '0) || (tile_words > MAX_WORDS);
  assign tile_inc = tile_reg + TILE_W'(1);

  // FINISH is left alone so a late abort cannot produce a second done pulse.
  assign stop = (state_reg != S_IDLE) && (state_reg != S_FINISH) && (abort || wdog_expire);

`ifdef FDTD_TILE_SCHED_WDOG_EN
  logic phase_active;

  assign phase_active = (state_reg == S_LOAD) || (state_reg == S_KSTART) ||
                        (state_reg == S_KRUN) || (state_reg == S_STORE);

  fdtd_sched_wdog #(
    .CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_next != state_reg),
    .enable  (phase_active),
    .expire  (wdog_expire)
  );
`else
  // Watchdog compiled out; WDOG_CYCLES only matters when it is built in.
  assign wdog_expire = 1'b0 & (WDOG_CYCLES != 32'd0);
`endif

  always_comb begin
    state_next   = state_reg;
    err_next     = err_reg;
    tile_next    = tile_reg;
    ntiles_next  = ntiles_reg;
    len_next     = len_reg;
    rd_addr_next = rd_addr_reg;
    wr_addr_next = wr_addr_reg;
    stride_next  = stride_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          tile_next    = '0;
          ntiles_next  = num_tiles;
          len_next     = tile_words;
          rd_addr_next = read_base;
          wr_addr_next = write_base;
          stride_next  = tile_stride;
          if (cfg_bad) begin
            err_next   = ERR_CFG;
            state_next = S_FINISH;
          end else if (num_tiles == '0) begin
            err_next   = ERR_OK;
            state_next = S_FINISH;
          end else begin
            err_next   = ERR_OK;
            state_next = S_LOAD;
          end
        end
      end
      S_LOAD:   if (ld_done) state_next = S_KSTART;
      S_KSTART: if (ap_ready) state_next = ap_done ? S_STORE : S_KRUN;
      S_KRUN:   if (ap_done) state_next = S_STORE;
      S_STORE:  if (st_done) state_next = S_NEXT;
      S_NEXT: begin
        rd_addr_next = rd_addr_reg + stride_reg;
        wr_addr_next = wr_addr_reg + stride_reg;
        if (tile_inc == ntiles_reg) begin
          state_next = S_FINISH;
        end else begin
          tile_next  = tile_inc;
          state_next = S_LOAD;
        end
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase

    // Abort and timeout override any same-cycle completion pulse.
    if (stop) begin
      state_next   = S_FINISH;
      err_next     = abort ? ERR_ABT : ERR_TMO;
      tile_next    = tile_reg;
      rd_addr_next = rd_addr_reg;
      wr_addr_next = wr_addr_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      err_reg     <= ERR_OK;
      tile_reg    <= '0;
      ntiles_reg  <= '0;
      len_reg     <= '0;
      rd_addr_reg <= '0;
      wr_addr_reg <= '0;
      stride_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      err_reg     <= err_next;
      tile_reg    <= tile_next;
      ntiles_reg  <= ntiles_next;
      len_reg     <= len_next;
      rd_addr_reg <= rd_addr_next;
      wr_addr_reg <= wr_addr_next;
      stride_reg  <= stride_next;
    end
  end

  assign ld_req   = (state_reg == S_LOAD);
  assign ap_start = (state_reg == S_KSTART);
  assign st_req   = (state_reg == S_STORE);
  assign busy     = (state_reg != S_IDLE);
  assign done     = (state_reg == S_FINISH);
  assign ld_addr  = rd_addr_reg;
  assign st_addr  = wr_addr_reg;
  assign ld_len   = len_reg;
  assign st_len   = len_reg;
  assign err      = err_reg;
  assign tile_idx = tile_reg;

endmodule
